// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: widths, reserved tag, supported opcodes and
// the reservation-station entry lifecycle.
package tomasulo_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int INST_W = 16;
    localparam int OP_W   = 4;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL = 4'b0100;

    typedef enum logic [1:0] {
        FREE,
        WAITING,
        READY,
        EXECUTING
    } rs_state_e;

    // True for opcodes the attached functional unit can execute.
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Bundle of issue, CDB and functional-unit handshake signals around one
// reservation station. slave = the station, master = its environment.
interface reservation_station_if #(
    parameter int ENTRIES = 3
);
    import tomasulo_pkg::*;

    localparam int CNT_W = $clog2(ENTRIES + 1);

    // issue side
    logic              issue_valid;
    logic              issue_ready;
    logic [INST_W-1:0] issue_inst;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic [TAG_W-1:0]  issued_tag;
    logic              bad_op;

    // common data bus
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    // functional unit
    logic              fu_available;
    logic              fu_start;
    logic [INST_W-1:0] fu_inst;
    logic [TAG_W-1:0]  fu_tag;
    logic [DATA_W-1:0] fu_reg1;
    logic [DATA_W-1:0] fu_reg2;

    logic [CNT_W-1:0]  busy_count;

    modport slave (
        input  issue_valid, issue_inst, issue_vj, issue_vk, issue_qj, issue_qk,
        input  cdb_valid, cdb_tag, cdb_data, fu_available,
        output issue_ready, issued_tag, bad_op,
        output fu_start, fu_inst, fu_tag, fu_reg1, fu_reg2, busy_count
    );

    modport master (
        output issue_valid, issue_inst, issue_vj, issue_vk, issue_qj, issue_qk,
        output cdb_valid, cdb_tag, cdb_data, fu_available,
        input  issue_ready, issued_tag, bad_op,
        input  fu_start, fu_inst, fu_tag, fu_reg1, fu_reg2, busy_count
    );

endinterface

// File: rtl/reservation_station_entry.sv
// One reservation-station slot: holds the instruction and its operands,
// snoops the CDB for pending operands and tracks the slot lifecycle.
module rs_entry
    import tomasulo_pkg::*;
#(
    parameter logic [TAG_W-1:0] TAG = 3'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_alloc,
    input  logic [INST_W-1:0] i_inst,
    input  logic [DATA_W-1:0] i_vj,
    input  logic [DATA_W-1:0] i_vk,
    input  logic [TAG_W-1:0]  i_qj,
    input  logic [TAG_W-1:0]  i_qk,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_data,
    input  logic              i_dispatch,
    output logic              o_free,
    output logic              o_ready,
    output logic              o_executing,
    output logic [INST_W-1:0] o_inst,
    output logic [DATA_W-1:0] o_vj,
    output logic [DATA_W-1:0] o_vk
);

    rs_state_e         r_state;
    logic [INST_W-1:0] r_inst;
    logic [DATA_W-1:0] r_vj;
    logic [DATA_W-1:0] r_vk;
    logic [TAG_W-1:0]  r_qj;
    logic [TAG_W-1:0]  r_qk;

    logic              w_cdb_live;
    logic [TAG_W-1:0]  w_src_qj;
    logic [TAG_W-1:0]  w_src_qk;
    logic [DATA_W-1:0] w_src_vj;
    logic [DATA_W-1:0] w_src_vk;
    logic              w_hit_j;
    logic              w_hit_k;
    logic [TAG_W-1:0]  w_nqj;
    logic [TAG_W-1:0]  w_nqk;
    logic [DATA_W-1:0] w_nvj;
    logic [DATA_W-1:0] w_nvk;

    // Operand capture shared by allocation (same-cycle forwarding from the
    // issue operands) and WAITING snoop (from the stored operands).
    always_comb begin
        w_cdb_live = i_cdb_valid && (i_cdb_tag != TAG_NONE);
        w_src_qj   = (r_state == FREE) ? i_qj : r_qj;
        w_src_qk   = (r_state == FREE) ? i_qk : r_qk;
        w_src_vj   = (r_state == FREE) ? i_vj : r_vj;
        w_src_vk   = (r_state == FREE) ? i_vk : r_vk;
        w_hit_j    = w_cdb_live && (w_src_qj == i_cdb_tag);
        w_hit_k    = w_cdb_live && (w_src_qk == i_cdb_tag);
        w_nqj      = w_hit_j ? TAG_NONE   : w_src_qj;
        w_nqk      = w_hit_k ? TAG_NONE   : w_src_qk;
        w_nvj      = w_hit_j ? i_cdb_data : w_src_vj;
        w_nvk      = w_hit_k ? i_cdb_data : w_src_vk;
    end

    // Slot lifecycle: allocate, wake up on CDB, dispatch, free on own tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= FREE;
            r_inst  <= '0;
            r_vj    <= '0;
            r_vk    <= '0;
            r_qj    <= '0;
            r_qk    <= '0;
        end else begin
            case (r_state)
                FREE: begin
                    if (i_alloc) begin
                        r_inst  <= i_inst;
                        r_vj    <= w_nvj;
                        r_vk    <= w_nvk;
                        r_qj    <= w_nqj;
                        r_qk    <= w_nqk;
                        r_state <= ((w_nqj == TAG_NONE) && (w_nqk == TAG_NONE))
                                   ? READY : WAITING;
                    end
                end
                WAITING: begin
                    r_vj    <= w_nvj;
                    r_vk    <= w_nvk;
                    r_qj    <= w_nqj;
                    r_qk    <= w_nqk;
                    r_state <= ((w_nqj == TAG_NONE) && (w_nqk == TAG_NONE))
                               ? READY : WAITING;
                end
                READY: begin
                    if (i_dispatch) begin
                        r_state <= EXECUTING;
                    end
                end
                EXECUTING: begin
                    if (i_cdb_valid && (i_cdb_tag == TAG)) begin
                        r_state <= FREE;
                    end
                end
                default: r_state <= FREE;
            endcase
        end
    end

    assign o_free      = (r_state == FREE);
    assign o_ready     = (r_state == READY);
    assign o_executing = (r_state == EXECUTING);
    assign o_inst      = r_inst;
    assign o_vj        = r_vj;
    assign o_vk        = r_vk;

endmodule

// File: rtl/reservation_station.sv
// Reservation station for one functional unit: lowest-index allocation and
// dispatch priority, registered FU dispatch interface and occupancy count.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int ENTRIES  = 3,
    parameter int TAG_BASE = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    reservation_station_if.slave  bus
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic [ENTRIES-1:0] w_free;
    logic [ENTRIES-1:0] w_ready;
    logic [ENTRIES-1:0] w_exec;
    logic [ENTRIES-1:0] w_alloc_vec;
    logic [ENTRIES-1:0] w_disp_vec;
    logic [INST_W-1:0]  w_ent_inst [ENTRIES];
    logic [DATA_W-1:0]  w_ent_vj   [ENTRIES];
    logic [DATA_W-1:0]  w_ent_vk   [ENTRIES];

    logic [IDX_W-1:0]   w_alloc_idx;
    logic [IDX_W-1:0]   w_disp_idx;
    logic               w_any_free;
    logic               w_any_ready;
    logic               w_op_ok;
    logic               w_issue_hs;
    logic               w_alloc_fire;
    logic               w_disp_fire;
    logic [CNT_W-1:0]   w_busy;

    logic               r_fu_start;
    logic [INST_W-1:0]  r_fu_inst;
    logic [TAG_W-1:0]   r_fu_tag;
    logic [DATA_W-1:0]  r_fu_reg1;
    logic [DATA_W-1:0]  r_fu_reg2;
    logic               r_bad_op;

    function automatic logic [TAG_W-1:0] f_tag(input logic [IDX_W-1:0] idx);
        return TAG_W'(TAG_BASE + int'(idx));
    endfunction

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        rs_entry #(
            .TAG (TAG_W'(TAG_BASE + g))
        ) u_entry (
            .clock       (clock),
            .reset       (reset),
            .i_alloc     (w_alloc_vec[g]),
            .i_inst      (bus.issue_inst),
            .i_vj        (bus.issue_vj),
            .i_vk        (bus.issue_vk),
            .i_qj        (bus.issue_qj),
            .i_qk        (bus.issue_qk),
            .i_cdb_valid (bus.cdb_valid),
            .i_cdb_tag   (bus.cdb_tag),
            .i_cdb_data  (bus.cdb_data),
            .i_dispatch  (w_disp_vec[g]),
            .o_free      (w_free[g]),
            .o_ready     (w_ready[g]),
            .o_executing (w_exec[g]),
            .o_inst      (w_ent_inst[g]),
            .o_vj        (w_ent_vj[g]),
            .o_vk        (w_ent_vk[g])
        );
    end

    // Lowest-index FREE and READY priority encoders plus occupancy count.
    always_comb begin
        w_alloc_idx = '0;
        w_any_free  = 1'b0;
        w_disp_idx  = '0;
        w_any_ready = 1'b0;
        w_busy      = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (w_free[i] && !w_any_free) begin
                w_alloc_idx = IDX_W'(i);
                w_any_free  = 1'b1;
            end
            if (w_ready[i] && !w_any_ready) begin
                w_disp_idx  = IDX_W'(i);
                w_any_ready = 1'b1;
            end
            if (!w_free[i]) begin
                w_busy = w_busy + CNT_W'(1);
            end
        end
    end

    // Handshake qualification and one-hot strobes to the entries.
    always_comb begin
        w_op_ok      = op_supported(bus.issue_inst[OP_W-1:0]);
        w_issue_hs   = bus.issue_valid && w_any_free;
        w_alloc_fire = w_issue_hs && w_op_ok;
        w_disp_fire  = bus.fu_available && !r_fu_start && !(|w_exec) && w_any_ready;
        w_alloc_vec  = '0;
        w_disp_vec   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            w_alloc_vec[i] = w_alloc_fire && (w_alloc_idx == IDX_W'(i));
            w_disp_vec[i]  = w_disp_fire  && (w_disp_idx  == IDX_W'(i));
        end
    end

    // Registered FU dispatch: one-cycle start pulse with latched operands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fu_start <= 1'b0;
            r_fu_inst  <= '0;
            r_fu_tag   <= TAG_NONE;
            r_fu_reg1  <= '0;
            r_fu_reg2  <= '0;
        end else begin
            r_fu_start <= w_disp_fire;
            if (w_disp_fire) begin
                r_fu_inst <= w_ent_inst[w_disp_idx];
                r_fu_tag  <= f_tag(w_disp_idx);
                r_fu_reg1 <= w_ent_vk[w_disp_idx];
                r_fu_reg2 <= w_ent_vj[w_disp_idx];
            end
        end
    end

    // Unsupported-opcode pulse; an offer while full is ignored entirely.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bad_op <= 1'b0;
        end else begin
            r_bad_op <= w_issue_hs && !w_op_ok;
        end
    end

    assign bus.issue_ready = w_any_free;
    assign bus.issued_tag  = w_any_free ? f_tag(w_alloc_idx) : TAG_NONE;
    assign bus.bad_op      = r_bad_op;
    assign bus.fu_start    = r_fu_start;
    assign bus.fu_inst     = r_fu_inst;
    assign bus.fu_tag      = r_fu_tag;
    assign bus.fu_reg1     = r_fu_reg1;
    assign bus.fu_reg2     = r_fu_reg2;
    assign bus.busy_count  = w_busy;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with hand-computed expectations.
module tb_reservation_station;
    import tomasulo_pkg::*;

    logic clock = 1'b0;
    logic reset;

    reservation_station_if #(.ENTRIES(3)) rs_if ();

    reservation_station #(
        .ENTRIES  (3),
        .TAG_BASE (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (rs_if)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rs_if.issue_valid = 1'b0;
        rs_if.issue_inst  = '0;
        rs_if.issue_vj    = '0;
        rs_if.issue_vk    = '0;
        rs_if.issue_qj    = '0;
        rs_if.issue_qk    = '0;
        rs_if.cdb_valid   = 1'b0;
        rs_if.cdb_tag     = '0;
        rs_if.cdb_data    = '0;
    endtask

    task automatic offer(input logic [15:0] inst, input logic [15:0] vj, input logic [15:0] vk,
                         input logic [2:0] qj, input logic [2:0] qk);
        rs_if.issue_valid = 1'b1;
        rs_if.issue_inst  = inst;
        rs_if.issue_vj    = vj;
        rs_if.issue_vk    = vk;
        rs_if.issue_qj    = qj;
        rs_if.issue_qk    = qk;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [15:0] data);
        rs_if.cdb_valid = 1'b1;
        rs_if.cdb_tag   = tag;
        rs_if.cdb_data  = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        rs_if.fu_available = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_issue_ready"}, rs_if.issue_ready, 1);
        check({pfx, "_fu_start"},    rs_if.fu_start,    0);
        check({pfx, "_fu_inst"},     rs_if.fu_inst,     0);
        check({pfx, "_fu_tag"},      rs_if.fu_tag,      0);
        check({pfx, "_fu_reg1"},     rs_if.fu_reg1,     0);
        check({pfx, "_fu_reg2"},     rs_if.fu_reg2,     0);
        check({pfx, "_bad_op"},      rs_if.bad_op,      0);
        check({pfx, "_busy"},        rs_if.busy_count,  0);
    endtask

    initial begin
        do_reset();
        check_reset_values("rst");

        // ready add dispatches one edge after allocation, freed by own tag
        rs_if.fu_available = 1'b1;
        offer(16'h0000, 16'd5, 16'd3, 3'd0, 3'd0);
        #1;
        check("t1_issued_tag", rs_if.issued_tag, 1);
        tick(); idle();
        check("t1_busy1", rs_if.busy_count, 1);
        check("t1_no_start_yet", rs_if.fu_start, 0);
        tick();
        check("t1_start", rs_if.fu_start, 1);
        check("t1_tag", rs_if.fu_tag, 1);
        check("t1_reg2", rs_if.fu_reg2, 5);
        check("t1_reg1", rs_if.fu_reg1, 3);
        check("t1_inst", rs_if.fu_inst, 0);
        tick();
        check("t1_start_pulse", rs_if.fu_start, 0);
        cdb(3'd1, 16'd8);
        tick(); idle();
        check("t1_busy0", rs_if.busy_count, 0);
        check("t1_ready", rs_if.issue_ready, 1);

        // waiting sub wakes on CDB tag 4
        offer(16'h0001, 16'd0, 16'd2, 3'd4, 3'd0);
        tick(); idle();
        check("t2_busy", rs_if.busy_count, 1);
        tick();
        check("t2_wait_no_start", rs_if.fu_start, 0);
        cdb(3'd4, 16'd10);
        tick(); idle();
        check("t2_wake_no_start", rs_if.fu_start, 0);
        tick();
        check("t2_start", rs_if.fu_start, 1);
        check("t2_reg2", rs_if.fu_reg2, 10);
        check("t2_reg1", rs_if.fu_reg1, 2);
        check("t2_inst", rs_if.fu_inst, 1);
        cdb(3'd1, 16'd8);
        tick(); idle();
        check("t2_busy0", rs_if.busy_count, 0);

        // same-cycle forwarding at issue
        offer(16'h0004, 16'd0, 16'd9, 3'd4, 3'd0);
        cdb(3'd4, 16'd7);
        tick(); idle();
        check("t3_busy", rs_if.busy_count, 1);
        tick();
        check("t3_start", rs_if.fu_start, 1);
        check("t3_reg2_fwd", rs_if.fu_reg2, 7);
        check("t3_reg1", rs_if.fu_reg1, 9);
        check("t3_inst", rs_if.fu_inst, 4);
        cdb(3'd1, 16'd63);
        tick(); idle();
        check("t3_busy0", rs_if.busy_count, 0);

        // full station, dispatch skips a waiting entry, freed slot reused
        do_reset();
        offer(16'h0000, 16'd0, 16'd0, 3'd6, 3'd0);
        tick();
        offer(16'h0000, 16'd1, 16'd2, 3'd0, 3'd0);
        #1;
        check("t4_tag2", rs_if.issued_tag, 2);
        tick();
        offer(16'h0000, 16'd3, 16'd4, 3'd0, 3'd0);
        #1;
        check("t4_tag3", rs_if.issued_tag, 3);
        tick(); idle();
        check("t4_full_ready", rs_if.issue_ready, 0);
        check("t4_full_busy", rs_if.busy_count, 3);
        offer(16'h0002, 16'd7, 16'd7, 3'd0, 3'd0);
        tick(); idle();
        check("t4_full_ignored_busy", rs_if.busy_count, 3);
        check("t4_full_no_bad_op", rs_if.bad_op, 0);
        rs_if.fu_available = 1'b1;
        tick();
        check("t4_start", rs_if.fu_start, 1);
        check("t4_skip_wait_tag", rs_if.fu_tag, 2);
        check("t4_reg2", rs_if.fu_reg2, 1);
        check("t4_reg1", rs_if.fu_reg1, 2);
        cdb(3'd2, 16'd3);
        tick(); idle();
        check("t4_freed_busy", rs_if.busy_count, 2);
        check("t4_freed_ready", rs_if.issue_ready, 1);
        offer(16'h0000, 16'd0, 16'd0, 3'd0, 3'd0);
        #1;
        check("t4_reuse_tag", rs_if.issued_tag, 2);
        tick(); idle();
        check("t4_reuse_busy", rs_if.busy_count, 3);
        check("t4_next_tag", rs_if.fu_tag, 3);
        check("t4_next_reg2", rs_if.fu_reg2, 3);

        // two ready entries, FU held busy, then in-order dispatch
        do_reset();
        offer(16'h0000, 16'd10, 16'd1, 3'd0, 3'd0);
        tick();
        offer(16'h0001, 16'd20, 16'd2, 3'd0, 3'd0);
        tick(); idle();
        tick();
        check("t5_hold_no_start", rs_if.fu_start, 0);
        check("t5_busy", rs_if.busy_count, 2);
        rs_if.fu_available = 1'b1;
        tick();
        check("t5_start0", rs_if.fu_start, 1);
        check("t5_tag0", rs_if.fu_tag, 1);
        check("t5_reg2_0", rs_if.fu_reg2, 10);
        tick();
        check("t5_blocked_a", rs_if.fu_start, 0);
        tick();
        check("t5_blocked_b", rs_if.fu_start, 0);
        cdb(3'd1, 16'd11);
        tick(); idle();
        check("t5_free_no_start", rs_if.fu_start, 0);
        check("t5_free_busy", rs_if.busy_count, 1);
        tick();
        check("t5_start1", rs_if.fu_start, 1);
        check("t5_tag1", rs_if.fu_tag, 2);
        check("t5_reg2_1", rs_if.fu_reg2, 20);
        check("t5_inst1", rs_if.fu_inst, 1);

        // unsupported opcode
        do_reset();
        offer(16'h0002, 16'd1, 16'd1, 3'd0, 3'd0);
        tick(); idle();
        check("t6_bad_op", rs_if.bad_op, 1);
        check("t6_bad_busy", rs_if.busy_count, 0);
        check("t6_bad_ready", rs_if.issue_ready, 1);
        tick();
        check("t6_bad_op_pulse", rs_if.bad_op, 0);

        // one broadcast satisfies both operands
        offer(16'h0000, 16'd0, 16'd0, 3'd3, 3'd3);
        tick(); idle();
        check("t7_busy", rs_if.busy_count, 1);
        cdb(3'd3, 16'd6);
        tick(); idle();
        rs_if.fu_available = 1'b1;
        tick();
        check("t7_start", rs_if.fu_start, 1);
        check("t7_reg1", rs_if.fu_reg1, 6);
        check("t7_reg2", rs_if.fu_reg2, 6);

        // reset while entry 1 executes; its late result is ignored
        do_reset();
        offer(16'h0000, 16'd0, 16'd0, 3'd5, 3'd0);
        tick();
        offer(16'h0000, 16'd4, 16'd4, 3'd0, 3'd0);
        tick(); idle();
        rs_if.fu_available = 1'b1;
        tick();
        check("t8_exec_tag", rs_if.fu_tag, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("t8_midrst");
        cdb(3'd2, 16'd9);
        tick(); idle();
        check("t8_stale_busy", rs_if.busy_count, 0);
        check("t8_stale_ready", rs_if.issue_ready, 1);
        check("t8_stale_start", rs_if.fu_start, 0);
        tick();
        check("t8_stale_tag", rs_if.fu_tag, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
